// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//
// Bit-serial adder. One operand bit pair is added per clock, LSB first,
// through a single full_adder cell. The cell is fed from two operand shift
// registers and a one-bit carry flip-flop. The result is shifted into the sum
// register MSB-first, so after WIDTH shifts the sum sits in its natural
// bit order.
//
// Timing for a start accepted at edge E:
//   - busy is high in the cycles following edges E .. E+WIDTH (RUN + DONE).
//   - done is high for one cycle, in the cycle following edge E+WIDTH.
//   - the edge after DONE returns to IDLE. A start held high is therefore
//     accepted once every WIDTH+2 cycles.
//
// sum, cout (and ovf) hold their final values from DONE until the next
// accepted start. They carry partial values while busy is high.
//
// Optional feature:
//   `define SERIAL_ADDER_OVF_EN adds output ovf. This is the two's-complement
//   signed overflow, equal to the carry into the MSB XOR the carry out of the
//   MSB. Without the macro the port and its logic do not exist.
//
// Parameter WIDTH: operand/sum width in bits, legal range 2..32.
// ---------------------------------------------------------------------------

// One-bit full adder cell: c is the sum bit, cout the carry out.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic c,
  output logic cout
);

  assign c    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             cout,
  output logic             ovf
`else
  output logic             cout
`endif
);

  // Counter must reach WIDTH without wrapping within one operation.
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             r_ovf;
`endif

  logic             w_sum_bit;
  logic             w_carry_out;
  logic             w_last;

  // The single adder cell. The current LSBs of the operand registers and the
  // carry flop form this cycle's bit slice.
  full_adder u_fa (
    .a   (r_a[0]),
    .b   (r_b[0]),
    .cin (r_carry),
    .c   (w_sum_bit),
    .cout(w_carry_out)
  );

  // The RUN cycle whose closing edge performs the WIDTH-th shift.
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  // Control FSM and datapath. All outputs are registered.
  // NOTE: sequential state uses non-blocking (<=) assignments so that every
  // flop samples its pre-edge value. Blocking here would create races between
  // the shift registers and the counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the datapath registers are reset as well as the control state.
      // sum/cout are visible outputs and must read 0 after reset. The operand
      // registers are cleared so that nothing stale ever reaches the cell.
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      // done is a one-cycle pulse. It is only raised on the RUN->DONE edge.
      r_done <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end

        ST_RUN: begin
          r_sum   <= {w_sum_bit, r_sum[WIDTH-1:1]};
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_carry_out;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            // r_carry is the carry into the MSB slice during this cycle.
            r_cout  <= w_carry_out;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf   <= r_carry ^ w_carry_out;
`endif
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end

        ST_DONE: begin
          // start is ignored here. An operation can only begin from IDLE.
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = r_ovf;
`endif

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and sum width in bits (legal range 2..32).
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request pulse; accepted only in IDLE.
REQ-005 a  input  WIDTH  operand A; sampled on the accepting edge only.
REQ-006 b  input  WIDTH  operand B; sampled on the accepting edge only.
REQ-007 cin  input  1  carry-in; sampled on the accepting edge only.
REQ-008 busy  output  1  high in RUN and DONE states.
REQ-009 done  output  1  one-cycle pulse marking a valid result.
REQ-010 sum  output  WIDTH  result of a + b + cin, modulo 2^WIDTH.
REQ-011 cout  output  1  carry out of bit WIDTH-1.

Function
REQ-012 The block SHALL compute one bit per clock, LSB first, using exactly one instance of the team's full_adder cell (ports a, b, cin, c, cout) fed from the operand shift registers and a 1-bit carry flip-flop.
REQ-013 The block SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 IDLE with start=1 at an edge -> SHALL latch a, b and cin, clear the bit counter, and go to RUN; busy=1 from the next cycle.
REQ-015 In RUN, each edge SHALL shift the full_adder sum bit into sum MSB-first (shift right), shift both operand registers right by one, load the carry flip-flop with the cell's cout, and increment the counter.
REQ-016 The edge performing the WIDTH-th shift SHALL move the state to DONE; cout SHALL equal the final carry.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle; the next edge SHALL return the state to IDLE.
REQ-018 Latency: start is accepted at edge E; done=1 in the cycle following edge E+WIDTH.
REQ-019 sum and cout SHALL hold their values from DONE until the next accepted start; they are unspecified while busy=1.
REQ-020 start in RUN or DONE SHALL be ignored (no queuing); start in the same cycle that done=1 SHALL NOT be accepted.
REQ-021 A change on a, b or cin after the accepting edge SHALL NOT affect the result.
REQ-022 The counter SHALL be ceil(log2(WIDTH+1)) bits wide, with no wrap-around within one operation.

Reset
REQ-023 reset=1 at an edge SHALL force IDLE with busy=0, done=0, sum=0, cout=0, carry flip-flop=0 and counter=0, regardless of state.
REQ-024 reset SHALL take priority over start; an operation interrupted mid-RUN SHALL be abandoned with no done pulse.

Configuration
REQ-025 Macro SERIAL_ADDER_OVF_EN: when defined, the block SHALL add an output port ovf (1 bit) giving two's-complement signed overflow, equal to the carry into the MSB XOR the carry out of the MSB. ovf SHALL be updated at the same time as cout, reset to 0, and hold its value with sum.
REQ-026 When SERIAL_ADDER_OVF_EN is undefined, the ovf port and its logic SHALL NOT exist; all other behaviour SHALL be identical.

Verification
REQ-027 WIDTH=8, a=0x3C, b=0x05, cin=0, start pulse -> done 9 cycles after the accepting edge, sum=0x41, cout=0, busy high for 9 cycles.
REQ-028 WIDTH=8, a=0xFF, b=0x01, cin=1 -> sum=0x01, cout=1; with SERIAL_ADDER_OVF_EN defined, ovf=0.
REQ-029 WIDTH=8, a=0x7F, b=0x01, cin=0, SERIAL_ADDER_OVF_EN defined -> sum=0x80, cout=0, ovf=1.
REQ-030 start held high continuously with a=0x10 and b=0x20, and a, b changed to 0xFF after acceptance -> exactly one done every 10 cycles (9 busy plus 1 IDLE), each result sum=0x30.
REQ-031 reset asserted at RUN cycle 4 -> next cycle state is IDLE with busy=0, sum=0, cout=0, and no done pulse; a following start with a=0x01, b=0x01 -> sum=0x02.
REQ-032 Randomized operands at WIDTH=4 and WIDTH=16, compared with a reference a+b+cin -> sum and cout match on every done pulse.
